// File: rtl/data_mem_dp_if.sv
// Load/store port bundle for data_mem_dp: write port, read port, clear request and status.
// The master drives the strobes and addresses; the slave returns read data, RdValid, Busy and Reject.
interface data_mem_dp_if #(
  parameter int W  = 8,
  parameter int AW = 8
);
  logic          WriteEn;
  logic [AW-1:0] WrAddr;
  logic [W-1:0]  DataIn;
  logic          ReadEn;
  logic [AW-1:0] RdAddr;
  logic          ClearReq;
  logic [W-1:0]  DataOut;
  logic          RdValid;
  logic          Busy;
  logic          Reject;

  modport master (
    output WriteEn, WrAddr, DataIn, ReadEn, RdAddr, ClearReq,
    input  DataOut, RdValid, Busy, Reject
  );

  modport slave (
    input  WriteEn, WrAddr, DataIn, ReadEn, RdAddr, ClearReq,
    output DataOut, RdValid, Busy, Reject
  );
endinterface

// File: rtl/data_mem_dp.sv
// Dual-address data memory: 1-cycle registered read with write-first bypass and a hardware clear sweep.
// While Busy (sweeping), accesses are dropped and flagged by a one-cycle Reject pulse; no stalling.
module data_mem_dp #(
  parameter int             W        = 8,
  parameter int             AW       = 8,
  parameter logic [W-1:0]   INIT_VAL = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  data_mem_dp_if.slave  bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [W-1:0]  mem_wd;
  logic [W-1:0]  core [DEPTH];
  logic          idle;

  assign idle     = (state_q == IDLE);
  assign bus.Busy = (state_q == CLEAR);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The sweep owns the single array write port while clearing; user writes only land in IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_we  = 1'b0;
    mem_wa  = bus.WrAddr;
    mem_wd  = bus.DataIn;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = ptr_q;
        mem_wd = INIT_VAL;
        ptr_d  = ptr_q + AW'(1);
        if (&ptr_q) state_d = IDLE;
      end
      IDLE: begin
        mem_we = bus.WriteEn;
        if (bus.ClearReq) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (mem_we) core[mem_wa] <= mem_wd;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.DataOut <= '0;
      bus.RdValid <= 1'b0;
      bus.Reject  <= 1'b0;
    end else begin
      bus.RdValid <= idle && bus.ReadEn;
      bus.Reject  <= !idle && (bus.WriteEn || bus.ReadEn);
      // Same-address write and read in one cycle returns the new data.
      if (idle && bus.ReadEn) begin
        if (bus.WriteEn && (bus.WrAddr == bus.RdAddr))
          bus.DataOut <= bus.DataIn;
        else
          bus.DataOut <= core[bus.RdAddr];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_dp.sv
// Directed bench for data_mem_dp: default build, INIT_VAL=0x5A build and W=16/AW=4 build.
module tb_data_mem_dp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_dp_if #(.W(8),  .AW(8)) b1();
  data_mem_dp_if #(.W(8),  .AW(8)) b2();
  data_mem_dp_if #(.W(16), .AW(4)) b3();

  data_mem_dp #(.W(8),  .AW(8), .INIT_VAL(8'h00)) u1 (.Clk(clk), .Reset(rst), .bus(b1.slave));
  data_mem_dp #(.W(8),  .AW(8), .INIT_VAL(8'h5A)) u2 (.Clk(clk), .Reset(rst), .bus(b2.slave));
  data_mem_dp #(.W(16), .AW(4), .INIT_VAL(16'h0)) u3 (.Clk(clk), .Reset(rst), .bus(b3.slave));

  typedef struct {
    logic       we;
    logic [7:0] wa;
    logic [7:0] din;
    logic       re;
    logic [7:0] ra;
    logic       vld;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[13];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    b1.WriteEn = 0; b1.WrAddr = '0; b1.DataIn = '0; b1.ReadEn = 0; b1.RdAddr = '0; b1.ClearReq = 0;
    b2.WriteEn = 0; b2.WrAddr = '0; b2.DataIn = '0; b2.ReadEn = 0; b2.RdAddr = '0; b2.ClearReq = 0;
    b3.WriteEn = 0; b3.WrAddr = '0; b3.DataIn = '0; b3.ReadEn = 0; b3.RdAddr = '0; b3.ClearReq = 0;
  endtask

  // Steps while u1 is busy; optionally injects a rejected write+read at sweep cycle inj.
  task automatic sweep_count(input int inj, output int n, output int n3);
    n  = 0;
    n3 = -1;
    while (b1.Busy && n < 1000) begin
      if (n == inj) begin
        b1.WriteEn = 1; b1.WrAddr = 8'h05; b1.DataIn = 8'hFF;
        b1.ReadEn  = 1; b1.RdAddr = 8'h05;
      end
      step();
      n++;
      if (n3 < 0 && !b3.Busy) n3 = n;
      if (n == inj + 1) begin
        chk("sweep_reject",   32'(b1.Reject),  32'd1);
        chk("sweep_rdvalid",  32'(b1.RdValid), 32'd0);
        chk("sweep_dataout",  32'(b1.DataOut), 32'h00);
        b1.WriteEn = 0; b1.ReadEn = 0;
      end
      if (n == inj + 2) chk("sweep_reject_pulse", 32'(b1.Reject), 32'd0);
    end
  endtask

  initial begin
    int n, n3;
    vecs = '{
      '{1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 1'b1, 8'h00},
      '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00},
      '{1'b0, 8'h00, 8'h00, 1'b1, 8'h7F, 1'b1, 8'h00},
      '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h00},
      '{1'b1, 8'h03, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00},
      '{1'b0, 8'h00, 8'h00, 1'b1, 8'h03, 1'b1, 8'hA5},
      '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5},
      '{1'b1, 8'h10, 8'h3C, 1'b1, 8'h10, 1'b1, 8'h3C},
      '{1'b1, 8'h10, 8'h3C, 1'b1, 8'h11, 1'b1, 8'h00},
      '{1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1, 8'h3C},
      '{1'b1, 8'h20, 8'h77, 1'b0, 8'h00, 1'b0, 8'h3C},
      '{1'b1, 8'h21, 8'h11, 1'b1, 8'h20, 1'b1, 8'h77},
      '{1'b0, 8'h00, 8'h00, 1'b1, 8'h21, 1'b1, 8'h11}
    };

    clr_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_busy",    32'(b1.Busy),    32'd1);
    chk("rst_dataout", 32'(b1.DataOut), 32'h0);
    chk("rst_rdvalid", 32'(b1.RdValid), 32'd0);
    chk("rst_reject",  32'(b1.Reject),  32'd0);
    rst = 1'b0;

    sweep_count(10, n, n3);
    chk("busy_len_after_reset", 32'(n),  32'd256);
    chk("busy_len_w16_aw4",     32'(n3), 32'd16);

    for (int i = 0; i < 13; i++) begin
      b1.WriteEn = vecs[i].we; b1.WrAddr = vecs[i].wa; b1.DataIn = vecs[i].din;
      b1.ReadEn  = vecs[i].re; b1.RdAddr = vecs[i].ra;
      step();
      chk($sformatf("vec%0d_rdvalid", i), 32'(b1.RdValid), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_dataout", i), 32'(b1.DataOut), 32'(vecs[i].dout));
      chk($sformatf("vec%0d_reject", i),  32'(b1.Reject),  32'd0);
      chk($sformatf("vec%0d_busy", i),    32'(b1.Busy),    32'd0);
    end
    clr_inputs();

    b1.ClearReq = 1;
    step();
    b1.ClearReq = 0;
    chk("clearreq_busy", 32'(b1.Busy), 32'd1);
    sweep_count(-5, n, n3);
    chk("busy_len_after_clearreq", 32'(n), 32'd256);
    b1.ReadEn = 1; b1.RdAddr = 8'h20;
    step();
    chk("cleared_rdvalid", 32'(b1.RdValid), 32'd1);
    chk("cleared_0x20",    32'(b1.DataOut), 32'h00);

    b1.ReadEn = 0; b1.WriteEn = 1; b1.WrAddr = 8'h20; b1.DataIn = 8'h99;
    step();
    b1.WriteEn = 0; b1.ReadEn = 1;
    step();
    b1.ReadEn = 0;
    chk("rewrite_0x20", 32'(b1.DataOut), 32'h99);
    b1.ClearReq = 1;
    step();
    b1.ClearReq = 0;
    for (int i = 0; i < 100; i++) step();
    chk("sweep_dataout_hold", 32'(b1.DataOut), 32'h99);
    rst = 1'b1;
    #1;
    chk("midsweep_rst_busy",    32'(b1.Busy),    32'd1);
    chk("midsweep_rst_dataout", 32'(b1.DataOut), 32'h00);
    step();
    rst = 1'b0;
    sweep_count(-5, n, n3);
    chk("busy_len_after_midsweep_rst", 32'(n), 32'd256);
    chk("dataout_after_midsweep_rst",  32'(b1.DataOut), 32'h00);

    b2.ReadEn = 1; b2.RdAddr = 8'h20;
    step();
    b2.ReadEn = 0;
    chk("init5a_rdvalid", 32'(b2.RdValid), 32'd1);
    chk("init5a_0x20",    32'(b2.DataOut), 32'h5A);

    b3.WriteEn = 1; b3.WrAddr = 4'hF; b3.DataIn = 16'hBEEF;
    step();
    b3.WriteEn = 0; b3.ReadEn = 1; b3.RdAddr = 4'hF;
    step();
    chk("w16_rdvalid", 32'(b3.RdValid), 32'd1);
    chk("w16_0xF",     32'(b3.DataOut), 32'hBEEF);
    b3.RdAddr = 4'h3;
    step();
    b3.ReadEn = 0;
    chk("w16_0x3", 32'(b3.DataOut), 32'h0000);
    step();
    chk("w16_rdvalid_drop", 32'(b3.RdValid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_dp.md
Name: data_mem_dp

Overview:
Parametrised successor to the single-pointer data memory, for the datapath's load/store unit.
- Separate write and read address ports; registered (1-cycle) read data with a valid flag; write-first bypass.
- Built-in hardware clear sequencer that sweeps every word to INIT_VAL after reset or on request, replacing the per-word reset loop.
- Sits between the ALU/regfile datapath and the load/store control; control must honour Busy.

Parameters:
W, 8, data word width in bits
AW, 8, address width; depth DEPTH = 2**AW words
INIT_VAL, 0, W-bit value written to every word by the clear sweep

Ports:
Clk  input  1  clock; all state updates on posedge
Reset  input  1  asynchronous, active-high reset
WriteEn  input  1  write strobe
WrAddr  input  AW  write address
DataIn  input  W  write data
ReadEn  input  1  read strobe
RdAddr  input  AW  read address
ClearReq  input  1  start a clear sweep (sampled only in IDLE)
DataOut  output  W  registered read data
RdValid  output  1  one-cycle pulse, DataOut updated this cycle
Busy  output  1  clear sweep in progress; accesses rejected
Reject  output  1  one-cycle pulse, WriteEn or ReadEn dropped because Busy

Behaviour:
- Reset (async, any cycle, including mid-sweep):
  - state=CLEAR, ptr=0, Busy=1, DataOut=0, RdValid=0, Reject=0.
  - Memory array is not reset directly; it is initialised only by the sweep.
- States: CLEAR and IDLE.
- CLEAR, each posedge:
  - Core[ptr] <= INIT_VAL, ptr <= ptr+1.
  - When ptr==DEPTH-1: write the last word, go to IDLE, Busy=0 from the next cycle.
  - Busy is high for exactly DEPTH cycles after Reset deasserts (or after a ClearReq acceptance).
- CLEAR, accesses:
  - WriteEn/ReadEn are ignored: no array write, RdValid=0, DataOut holds its value.
  - Reject=1 the cycle after any such strobe (registered, one cycle per offending cycle).
  - ClearReq is ignored.
- IDLE, write: WriteEn=1 -> Core[WrAddr] <= DataIn at posedge.
- IDLE, read: ReadEn=1 -> at posedge DataOut <= Core[RdAddr], RdValid <= 1. Read latency 1 cycle.
  - ReadEn=0 -> RdValid <= 0, DataOut holds its last value.
- IDLE, simultaneous WriteEn and ReadEn with WrAddr==RdAddr: write-first; DataOut <= DataIn.
  - Different addresses: independent; old data is read.
- IDLE, ClearReq=1: go to CLEAR, ptr=0, Busy=1 next cycle.
  - A write or read presented in the same cycle as ClearReq is still performed (IDLE rules); the sweep then overwrites the array.
- Address and width rules:
  - Addresses are AW bits, so there is no out-of-range access.
  - ptr is AW bits and wraps to 0 after DEPTH-1 (the wrap coincides with the IDLE transition).
  - INIT_VAL is truncated/zero-extended to W.
- RdValid and Reject never assert in the same cycle for the same request.

Test Plan:
1. Default params, deassert Reset -> Busy=1 for exactly 256 cycles then 0; then ReadEn RdAddr=0x00, 0x7F, 0xFF -> DataOut=0x00, RdValid pulses each.
2. IDLE, write WrAddr=0x03 DataIn=0xA5, next cycle ReadEn RdAddr=0x03 -> following cycle DataOut=0xA5, RdValid=1 for 1 cycle.
3. Same cycle WriteEn WrAddr=0x10 DataIn=0x3C and ReadEn RdAddr=0x10 (old value 0x00) -> DataOut=0x3C next cycle (bypass); repeat with RdAddr=0x11 -> DataOut=0x00.
4. During sweep, WriteEn WrAddr=0x05 DataIn=0xFF and ReadEn -> Reject=1 next cycle, RdValid=0; after Busy falls, read 0x05 -> 0x00.
5. Write 0x77 to 0x20, pulse ClearReq -> Busy 256 cycles, then read 0x20 -> INIT_VAL (0x00); with INIT_VAL=0x5A -> 0x5A.
6. Assert Reset at sweep ptr=100, release -> Busy 256 full cycles again, DataOut=0; W=16, AW=4 build -> Busy 16 cycles, write/read 0xBEEF at 0xF returns 0xBEEF.
